output_port_arbiter: RTL and testbench
======================================

Name: output_port_arbiter

Overview:
- Per-output-port switch allocator for the 5-port mesh router. It sits between the five input-port LBDR units and one output port.
- Takes the one-bit port request each LBDR asserts for this output and grants the port to one input at a time with round-robin fairness.
- Holds the grant for the whole packet (HEADER through TAIL) and generates read strobes toward the owning input FIFO, gated by downstream backpressure.
- The router instantiates one arbiter per output: N, E, W, S, L.

Parameters:
- NUM_IN, 5, number of requesting input ports. Index order 0=N, 1=E, 2=W, 3=S, 4=L.
- FLIT_ID_W, 3, width of the flit_id field.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NUM_IN  request for this output; bit i comes from input i's LBDR port bit
- empty  in  NUM_IN  input FIFO i empty
- flit_id_in  in  NUM_IN*FLIT_ID_W  flit_id at the head of each input FIFO; input i occupies bits [i*3+2:i*3]
- out_full  in  1  downstream buffer full
- grant  out  NUM_IN  one-hot owner of this output; all zero when idle
- read_en  out  NUM_IN  pop strobe to input FIFO i; one-hot or zero
- valid_out  out  1  a flit crosses the crossbar this cycle (equals OR of read_en)
- sel  out  3  crossbar mux select, binary index of the owner; 0 when idle

Behaviour:
- Reset (rst=1 at a clk edge):
  - grant=0, state=IDLE, sel=0.
  - rr_ptr=NUM_IN-1, so input 0 has highest priority on the first arbitration.
  - read_en and valid_out are 0 while rst is high, regardless of other inputs.
- State machine, two states:
  - IDLE: arbitrate only on a "header-valid" request, i.e. req[i] & ~empty[i] & flit_id(i)==HEADER.
    - Priority order is rr_ptr+1, rr_ptr+2, ... modulo NUM_IN.
    - The winner w is registered: grant<=onehot(w), sel<=w, state<=LOCKED.
    - Grant is visible one cycle after the request is sampled. No reads occur in IDLE.
  - LOCKED: read_en[w] = grant[w] & ~empty[w] & ~out_full, combinational from registered grant plus live inputs. valid_out = |read_en.
    - When read_en[w]=1 and flit_id(w)==TAIL: next cycle grant<=0, sel<=0, rr_ptr<=w, state<=IDLE.
    - Each packet therefore costs one bubble cycle before re-arbitration.
- Grant hold rules:
  - req[w] falling while LOCKED is ignored; the grant is held until the TAIL is popped.
  - empty[w] or out_full stalls the read only; the grant is kept with no timeout.
  - A HEADER at the owner's head while LOCKED (malformed, TAIL missing) is popped as data; the grant is kept.
- Single-flit packet: flit_id==TAIL with no HEADER is not arbitrated and never granted.
- rr_ptr changes only on TAIL release; it is not updated by a grant alone.
- Simultaneous events:
  - TAIL pop on the same edge as new requests: the new requests wait for the IDLE cycle.
  - rst together with a TAIL pop: reset wins.
- Reset mid-packet: the grant is dropped immediately and the remaining flits are not read. Flushing the FIFOs is the input side's job.
- Invariant (assert in bench): grant, read_en and sel-decode are always one-hot or zero, and read_en is a subset of grant.

Decomposition:
- Shared package router_pkg holds:
  - flit_id encodings HEADER=3'b001, PAYLOAD=3'b010, TAIL=3'b100 (same values as the existing parameters include);
  - port index constants P_N..P_L;
  - NUM_PORTS=5;
  - arb_state_t enum {IDLE, LOCKED}.
- One natural sub-module: rr_priority_picker. It is combinational: inputs req vector and rr_ptr; outputs one-hot winner and binary index. It is reusable for VC allocation.

Test Plan:
- Reset then req=5'b00001, empty=0, flit_id(0)=HEADER -> grant=5'b00001 and sel=0 one cycle later. Next cycle read_en=5'b00001, valid_out=1.
- Input 2 sends a 4-flit packet H,P,P,T with out_full=0 -> read_en[2] high 4 consecutive cycles, grant drops the cycle after T pops, rr_ptr=2.
- All five header-valid requests continuously, each packet H,T -> grant order 0,1,2,3,4,0 with one idle cycle between packets.
- Owner 3 mid-packet with out_full=1 for 3 cycles -> read_en=0 and grant=5'b01000 held. Pops resume when out_full=0, and flit count is preserved.
- Owner 1 drops req after HEADER pop while input 4 requests -> grant stays 5'b00010 until TAIL pops, then input 4 is granted.
- rst asserted the cycle after a PAYLOAD pop -> grant, read_en and valid_out go to 0 at that edge, and the next arbitration starts from input 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the 5-port mesh router: flit identifiers, port
// indices and the output arbiter state type.
package router_pkg;

  localparam int NUM_PORTS = 5;

  localparam int P_N = 0;
  localparam int P_E = 1;
  localparam int P_W = 2;
  localparam int P_S = 3;
  localparam int P_L = 4;

  localparam logic [2:0] HEADER  = 3'b001;
  localparam logic [2:0] PAYLOAD = 3'b010;
  localparam logic [2:0] TAIL    = 3'b100;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  // Index of the candidate that sits 'offset' places after 'base' in a ring of n
  function automatic int wrapIndex(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/output_port_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: scans requests starting one place after
// the pointer and reports the first hit as both one-hot and binary index.
// Kept generic so VC allocation can reuse it.
module rr_priority_picker
  import router_pkg::*;
#(
  parameter int N     = NUM_PORTS,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_rrPtr,
  output logic [N-1:0]     o_winOneHot,
  output logic [IDX_W-1:0] o_winIdx,
  output logic             o_winValid
);

  logic [IDX_W-1:0] w_cand;

  // Walk the ring from rr_ptr+1 and keep the first requester found
  always_comb begin
    o_winOneHot = '0;
    o_winIdx    = '0;
    o_winValid  = 1'b0;
    w_cand      = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IDX_W'(wrapIndex(int'(i_rrPtr), k, N));
      if (!o_winValid && i_req[w_cand]) begin
        o_winValid          = 1'b1;
        o_winOneHot[w_cand] = 1'b1;
        o_winIdx            = w_cand;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Switch allocator for one router output. Grants the output to one input at
// a time with round-robin fairness, holds the grant from HEADER to TAIL and
// pops the owner's FIFO whenever it has data and downstream has room.
module output_port_arbiter
  import router_pkg::*;
#(
  parameter int NUM_IN    = 5,
  parameter int FLIT_ID_W = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_IN-1:0]             req,
  input  logic [NUM_IN-1:0]             empty,
  input  logic [NUM_IN*FLIT_ID_W-1:0]   flit_id_in,
  input  logic                          out_full,
  output logic [NUM_IN-1:0]             grant,
  output logic [NUM_IN-1:0]             read_en,
  output logic                          valid_out,
  output logic [2:0]                    sel
);

  localparam int SEL_W = 3;

  arb_state_t          r_state, w_nextState;
  logic [NUM_IN-1:0]   r_grant, w_nextGrant;
  logic [SEL_W-1:0]    r_sel, w_nextSel;
  logic [SEL_W-1:0]    r_rrPtr, w_nextRrPtr;

  logic [FLIT_ID_W-1:0] w_flitId [NUM_IN];
  logic [FLIT_ID_W-1:0] w_ownerFlit;
  logic [NUM_IN-1:0]    w_hdrValid;
  logic [NUM_IN-1:0]    w_winOneHot;
  logic [SEL_W-1:0]     w_winIdx;
  logic                 w_winValid;
  logic [NUM_IN-1:0]    w_readEn;
  logic                 w_tailPop;

  // Unpack per-input flit ids; only a HEADER at a non-empty head may compete
  always_comb begin
    w_hdrValid = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_flitId[i]   = flit_id_in[i*FLIT_ID_W +: FLIT_ID_W];
      w_hdrValid[i] = req[i] & ~empty[i] & (w_flitId[i] == HEADER);
    end
  end

  rr_priority_picker #(
    .N     (NUM_IN),
    .IDX_W (SEL_W)
  ) u_picker (
    .i_req       (w_hdrValid),
    .i_rrPtr     (r_rrPtr),
    .o_winOneHot (w_winOneHot),
    .o_winIdx    (w_winIdx),
    .o_winValid  (w_winValid)
  );

  assign w_ownerFlit = w_flitId[r_sel];

  // Pop the owner's FIFO when it has data and downstream can accept; never during reset
  always_comb begin
    w_readEn = '0;
    if (!rst && (r_state == LOCKED)) begin
      w_readEn = r_grant & ~empty & {NUM_IN{~out_full}};
    end
    w_tailPop = (|w_readEn) && (w_ownerFlit == TAIL);
  end

  // Arbitrate in IDLE, release only when the owner's TAIL actually leaves
  always_comb begin
    w_nextState = r_state;
    w_nextGrant = r_grant;
    w_nextSel   = r_sel;
    w_nextRrPtr = r_rrPtr;
    case (r_state)
      IDLE: begin
        if (w_winValid) begin
          w_nextGrant = w_winOneHot;
          w_nextSel   = w_winIdx;
          w_nextState = LOCKED;
        end
      end
      LOCKED: begin
        if (w_tailPop) begin
          w_nextGrant = '0;
          w_nextSel   = '0;
          w_nextRrPtr = r_sel;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State registers; reset leaves input 0 first in line
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_rrPtr <= SEL_W'(NUM_IN - 1);
    end else begin
      r_state <= w_nextState;
      r_grant <= w_nextGrant;
      r_sel   <= w_nextSel;
      r_rrPtr <= w_nextRrPtr;
    end
  end

  assign grant     = r_grant;
  assign read_en   = w_readEn;
  assign valid_out = |w_readEn;
  assign sel       = r_sel;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: input FIFOs are modelled as
// queues, and a packet-level reference (owner / last-served pointer) predicts
// every output each cycle. Directed scenarios come first, then random traffic.
module tb_output_port_arbiter;
  import router_pkg::*;

  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   empty;
  logic [N*3-1:0] flit_id_in;
  logic           out_full;
  logic [N-1:0]   grant;
  logic [N-1:0]   read_en;
  logic           valid_out;
  logic [2:0]     sel;

  logic [2:0]   fifoQ [N][$];
  logic [N-1:0] reqMask;

  int           mOwner;
  int           mPtr;
  logic [N-1:0] expGrant;
  logic [N-1:0] expRead;
  logic [2:0]   expSel;

  int           checkCount;
  int           passCount;
  int           dutReads [N];
  int           history [$];
  logic [N-1:0] prevGrant;

  output_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .empty      (empty),
    .flit_id_in (flit_id_in),
    .out_full   (out_full),
    .grant      (grant),
    .read_en    (read_en),
    .valid_out  (valid_out),
    .sel        (sel)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pushPkt(input int port, input int nPayload);
    fifoQ[port].push_back(HEADER);
    for (int k = 0; k < nPayload; k++) fifoQ[port].push_back(PAYLOAD);
    fifoQ[port].push_back(TAIL);
  endtask

  // Present FIFO heads and requests to the DUT
  task automatic applyStimulus();
    req = reqMask;
    for (int i = 0; i < N; i++) begin
      empty[i] = (fifoQ[i].size() == 0);
      flit_id_in[i*3 +: 3] = empty[i] ? 3'b000 : fifoQ[i][0];
    end
  endtask

  // Compare every output with the packet-level reference, plus invariants
  task automatic checkOutput();
    logic [7:0] selDec;
    expGrant = '0;
    expSel   = '0;
    expRead  = '0;
    if (mOwner >= 0) begin
      expGrant[mOwner] = 1'b1;
      expSel = 3'(mOwner);
      if (!rst && fifoQ[mOwner].size() > 0 && !out_full) expRead[mOwner] = 1'b1;
    end
    checkVal("grant", grant, expGrant);
    checkVal("sel", sel, expSel);
    checkVal("read_en", read_en, expRead);
    checkVal("valid_out", valid_out, |expRead);
    checkVal("grant_onehot0", $onehot0(grant), 1);
    checkVal("read_subset", read_en & ~grant, 0);
    selDec = (grant != '0) ? (8'b1 << sel) : 8'b0;
    checkVal("sel_decode", selDec, {3'b000, grant});
    if (grant != '0 && grant != prevGrant) begin
      for (int i = 0; i < N; i++) if (grant[i]) history.push_back(i);
    end
    prevGrant = grant;
    for (int i = 0; i < N; i++) dutReads[i] += int'(read_en[i]);
  endtask

  // Reference update at the clock edge: reset, TAIL release, or fresh arbitration
  task automatic modelEdge();
    if (rst) begin
      mOwner = -1;
      mPtr   = N - 1;
    end else if (mOwner >= 0) begin
      if (expRead[mOwner] && fifoQ[mOwner][0] == TAIL) begin
        mPtr   = mOwner;
        mOwner = -1;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (mPtr + k) % N;
        if (mOwner < 0 && reqMask[c] && fifoQ[c].size() > 0 && fifoQ[c][0] == HEADER) mOwner = c;
      end
    end
    for (int i = 0; i < N; i++) if (expRead[i]) void'(fifoQ[i].pop_front());
  endtask

  task automatic tick();
    applyStimulus();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic runTicks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clearReads();
    for (int i = 0; i < N; i++) dutReads[i] = 0;
  endtask

  // Directed scenarios followed by random traffic
  initial begin
    int sum;
    checkCount = 0;
    passCount  = 0;
    mOwner     = -1;
    mPtr       = N - 1;
    prevGrant  = '0;
    clearReads();
    rst        = 1'b1;
    out_full   = 1'b0;
    reqMask    = '0;
    applyStimulus();

    runTicks(2);
    rst = 1'b0;
    checkVal("reset_grant", grant, 0);
    checkVal("reset_sel", sel, 0);

    $display("[TB] single header on input N");
    pushPkt(P_N, 0);
    reqMask = 5'b00001;
    tick();
    checkVal("t1_grant", grant, 5'b00001);
    checkVal("t1_sel", sel, 0);
    runTicks(2);
    checkVal("t1_release", grant, 0);
    tick();
    reqMask = '0;

    $display("[TB] four-flit packet on input W");
    clearReads();
    pushPkt(P_W, 2);
    reqMask = 5'b00100;
    tick();
    checkVal("t2_grant", grant, 5'b00100);
    checkVal("t2_sel", sel, 2);
    runTicks(4);
    checkVal("t2_release", grant, 0);
    checkVal("t2_reads", dutReads[P_W], 4);
    history.delete();
    pushPkt(P_N, 0);
    pushPkt(P_S, 0);
    reqMask = 5'b01001;
    tick();
    checkVal("t2_ptr_next", grant, 5'b01000);
    runTicks(7);
    checkVal("t2_hist_len", history.size(), 2);
    if (history.size() == 2) begin
      checkVal("t2_hist0", history[0], P_S);
      checkVal("t2_hist1", history[1], P_N);
    end
    reqMask = '0;

    $display("[TB] all five inputs competing");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    history.delete();
    clearReads();
    for (int i = 0; i < N; i++) begin
      pushPkt(i, 0);
      pushPkt(i, 0);
    end
    reqMask = 5'b11111;
    runTicks(34);
    checkVal("t3_hist_len", history.size(), 10);
    for (int k = 0; k < history.size() && k < 10; k++) checkVal("t3_order", history[k], k % N);
    sum = 0;
    for (int i = 0; i < N; i++) sum += dutReads[i];
    checkVal("t3_reads", sum, 20);
    reqMask = '0;

    $display("[TB] backpressure on owner S");
    clearReads();
    pushPkt(P_S, 3);
    reqMask = 5'b01000;
    runTicks(3);
    out_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkVal("t4_stall_grant", grant, 5'b01000);
      checkVal("t4_stall_read", read_en, 0);
    end
    out_full = 1'b0;
    runTicks(5);
    checkVal("t4_release", grant, 0);
    checkVal("t4_reads", dutReads[P_S], 5);
    reqMask = '0;

    $display("[TB] owner E drops request mid-packet");
    history.delete();
    pushPkt(P_E, 1);
    reqMask = 5'b00010;
    tick();
    checkVal("t5_grant", grant, 5'b00010);
    tick();
    reqMask = 5'b10000;
    pushPkt(P_L, 0);
    tick();
    checkVal("t5_hold", grant, 5'b00010);
    tick();
    checkVal("t5_release", grant, 0);
    tick();
    checkVal("t5_next", grant, 5'b10000);
    runTicks(3);
    checkVal("t5_hist_len", history.size(), 2);
    if (history.size() == 2) begin
      checkVal("t5_hist0", history[0], P_E);
      checkVal("t5_hist1", history[1], P_L);
    end
    reqMask = '0;

    $display("[TB] reset in the middle of a packet");
    pushPkt(P_E, 0);
    reqMask = 5'b00010;
    runTicks(4);
    pushPkt(P_W, 2);
    reqMask = 5'b00100;
    tick();
    checkVal("t6_grant", grant, 5'b00100);
    runTicks(2);
    rst = 1'b1;
    tick();
    checkVal("t6_rst_grant", grant, 0);
    checkVal("t6_rst_sel", sel, 0);
    checkVal("t6_rst_read", read_en, 0);
    checkVal("t6_rst_valid", valid_out, 0);
    rst = 1'b0;
    fifoQ[P_W].delete();
    history.delete();
    pushPkt(P_N, 0);
    pushPkt(P_W, 0);
    reqMask = 5'b00101;
    tick();
    checkVal("t6_first_after_rst", grant, 5'b00001);
    runTicks(6);
    checkVal("t6_hist_len", history.size(), 2);
    reqMask = '0;

    $display("[TB] lone TAIL is never granted");
    history.delete();
    fifoQ[P_S].push_back(TAIL);
    reqMask = 5'b01000;
    runTicks(4);
    checkVal("t7_no_grant", history.size(), 0);
    checkVal("t7_grant", grant, 0);
    fifoQ[P_S].delete();
    reqMask = '0;
    tick();

    $display("[TB] random traffic");
    for (int n = 0; n < 500; n++) begin
      rst      = ($urandom_range(0, 49) == 0);
      out_full = ($urandom_range(0, 3) == 0);
      reqMask  = 5'($urandom);
      for (int i = 0; i < N; i++) begin
        if (fifoQ[i].size() < 6 && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 2))
            0:       fifoQ[i].push_back(HEADER);
            1:       fifoQ[i].push_back(PAYLOAD);
            default: fifoQ[i].push_back(TAIL);
          endcase
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
